// File: rtl/cpu_core.sv
// cpu_core: single-cycle 32-bit MIPS subset with back-door accessible instruction/data memories.
// Optional macro SYSCALL_HALT_EN: freeze PC and all writes after SYSCALL until reset.

module instr_mem (
    input  logic        clock,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] instr
);
    logic [31:0] mem [0:1023];

    // Write port is tied off in the core; the array is normally loaded back-door.
    always_ff @(posedge clock) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign instr = mem[addr];
endmodule

module data_mem (
    input  logic        clock,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] d_mem [0:3071];

    always_ff @(posedge clock) begin
        if (we)
            d_mem[addr] <= wdata;
    end

    assign rdata = d_mem[addr];
endmodule

module reg_file (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    // $gp and $sp come out of reset pointing into data memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                registers[i] <= 32'd0;
            registers[28] <= 32'h0000_1800;
            registers[29] <= 32'h0000_2FFC;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module cpu_core (
    input  logic clock,
    input  logic reset,
    output logic syscall
);
    logic [31:0] pc, pc_plus4, next_pc, instr;
    logic [31:0] rs_val, rt_val, mem_rdata, reg_wd;
    logic [31:0] sext_imm, zext_imm, addr_sum, branch_target, jump_target;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, reg_wa;
    logic        reg_we, mem_we, is_syscall, halted;

    assign opcode        = instr[31:26];
    assign rs            = instr[25:21];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign shamt         = instr[10:6];
    assign funct         = instr[5:0];
    assign sext_imm      = {{16{instr[15]}}, instr[15:0]};
    assign zext_imm      = {16'd0, instr[15:0]};
    assign addr_sum      = rs_val + sext_imm;
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign jump_target   = {pc[31:28], instr[25:0], 2'b00};

`ifdef SYSCALL_HALT_EN
    assign halted = syscall;
`else
    assign halted = 1'b0;
`endif

    // Program space starts at 0x3000, so bits [11:2] index the 1024-word ROM directly.
    instr_mem instr_mem_0 (
        .clock (clock),
        .we    (1'b0),
        .addr  (pc[11:2]),
        .wdata (32'd0),
        .instr (instr)
    );

    reg_file reg_file_0 (
        .clock (clock),
        .reset (reset),
        .we    (reg_we & ~halted),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (reg_wa),
        .wd    (reg_wd),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    data_mem data_mem_0 (
        .clock (clock),
        .we    (mem_we & ~halted),
        .addr  (addr_sum[13:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    // Decode and execute; anything not listed falls through as a NOP.
    always_comb begin
        reg_we     = 1'b0;
        reg_wa     = rt;
        reg_wd     = 32'd0;
        mem_we     = 1'b0;
        is_syscall = 1'b0;
        next_pc    = pc_plus4;
        case (opcode)
            6'h00: begin
                reg_wa = rd;
                reg_we = 1'b1;
                case (funct)
                    6'h20, 6'h21: reg_wd = rs_val + rt_val;
                    6'h22, 6'h23: reg_wd = rs_val - rt_val;
                    6'h24:        reg_wd = rs_val & rt_val;
                    6'h25:        reg_wd = rs_val | rt_val;
                    6'h26:        reg_wd = rs_val ^ rt_val;
                    6'h27:        reg_wd = ~(rs_val | rt_val);
                    6'h2A:        reg_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B:        reg_wd = {31'd0, rs_val < rt_val};
                    6'h00:        reg_wd = rt_val << shamt;
                    6'h02:        reg_wd = rt_val >> shamt;
                    6'h03:        reg_wd = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        reg_we  = 1'b0;
                        next_pc = rs_val;
                    end
                    6'h0C: begin
                        reg_we     = 1'b0;
                        is_syscall = 1'b1;
                    end
                    default:      reg_we = 1'b0;
                endcase
            end
            6'h02: next_pc = jump_target;
            6'h03: begin
                reg_we  = 1'b1;
                reg_wa  = 5'd31;
                reg_wd  = pc_plus4;
                next_pc = jump_target;
            end
            6'h04: if (rs_val == rt_val) next_pc = branch_target;
            6'h05: if (rs_val != rt_val) next_pc = branch_target;
            6'h08, 6'h09: begin
                reg_we = 1'b1;
                reg_wd = addr_sum;
            end
            6'h0A: begin
                reg_we = 1'b1;
                reg_wd = {31'd0, $signed(rs_val) < $signed(sext_imm)};
            end
            6'h0B: begin
                reg_we = 1'b1;
                reg_wd = {31'd0, rs_val < sext_imm};
            end
            6'h0C: begin
                reg_we = 1'b1;
                reg_wd = rs_val & zext_imm;
            end
            6'h0D: begin
                reg_we = 1'b1;
                reg_wd = rs_val | zext_imm;
            end
            6'h0E: begin
                reg_we = 1'b1;
                reg_wd = rs_val ^ zext_imm;
            end
            6'h0F: begin
                reg_we = 1'b1;
                reg_wd = {instr[15:0], 16'd0};
            end
            6'h23: begin
                reg_we = 1'b1;
                reg_wd = mem_rdata;
            end
            6'h2B: mem_we = 1'b1;
            default: ;
        endcase
    end

    // Without the halt option, syscall is a one-cycle pulse; with it, syscall gates further commits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= 32'h0000_3000;
            syscall <= 1'b0;
        end else if (!halted) begin
            pc      <= next_pc;
            syscall <= is_syscall;
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven and sequence checks of cpu_core with a queue-based scoreboard.
// Expectations for the post-SYSCALL behaviour follow SYSCALL_HALT_EN.

module tb_cpu_core;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int K_REG  = 0;
    localparam int K_DMEM = 1;
    localparam int K_PC   = 2;
    localparam int K_SYS  = 3;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          dst;
        logic [31:0] expected;
    } vec_t;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] expected;
    } exp_t;

    logic clock     = 1'b0;
    logic reset     = 1'b1;
    logic clock_run = 1'b0;
    logic syscall;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    exp_t        sb_q[$];
    vec_t        vecs[$];
    logic [31:0] prog[$];

    cpu_core dut (
        .clock   (clock),
        .reset   (reset),
        .syscall (syscall)
    );

    always #5 if (clock_run) clock = ~clock;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int addr);
        logic [31:0] a;
        a = 32'(addr);
        return {6'(op), a[27:2]};
    endfunction

    function automatic logic [31:0] probe(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.reg_file_0.registers[idx];
            K_DMEM:  return dut.data_mem_0.d_mem[idx];
            K_PC:    return dut.pc;
            default: return {31'd0, syscall};
        endcase
    endfunction

    task automatic add_vec(input string name, input logic [31:0] instr, input int dst, input logic [31:0] expected);
        vec_t v;
        v.name = name;
        v.instr = instr;
        v.dst = dst;
        v.expected = expected;
        vecs.push_back(v);
    endtask

    task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] value);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx = idx;
        e.expected = value;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        logic [31:0] actual;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            actual = probe(e.kind, e.idx);
            n_compared++;
            if (actual !== e.expected) begin
                n_mismatched++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, actual, e.expected);
            end
        end
    endtask

    // Reset with the clock stopped, then load the program after release and restart the clock.
    task automatic apply_stimulus();
        clock_run = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 1024; i++)
            dut.instr_mem_0.mem[i] = 32'd0;
        foreach (prog[i])
            dut.instr_mem_0.mem[i] = prog[i];
        #1;
        clock_run = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        // Reset alone, clock never started.
        #1 reset = 1'b0;
        #4;
        expect_val("rst_pc", K_PC, 0, RESET_PC);
        expect_val("rst_gp", K_REG, 28, 32'h0000_1800);
        expect_val("rst_sp", K_REG, 29, 32'h0000_2FFC);
        expect_val("rst_t0", K_REG, 8, 32'd0);
        expect_val("rst_sys", K_SYS, 0, 32'd0);
        check_output();

        // One instruction per edge; each record names the register it must leave behind.
        add_vec("lui",      enc_i(6'h0F, 0, 8, 16'hF0F0),   8, 32'hF0F0_0000);
        add_vec("ori",      enc_i(6'h0D, 8, 8, 16'h1234),   8, 32'hF0F0_1234);
        add_vec("addi_neg", enc_i(6'h08, 0, 9, -3),          9, 32'hFFFF_FFFD);
        add_vec("add",      enc_r(8, 9, 10, 0, 6'h20),      10, 32'hF0F0_1231);
        add_vec("addu",     enc_r(8, 9, 11, 0, 6'h21),      11, 32'hF0F0_1231);
        add_vec("sub",      enc_r(8, 9, 12, 0, 6'h22),      12, 32'hF0F0_1237);
        add_vec("subu",     enc_r(9, 8, 13, 0, 6'h23),      13, 32'h0F0F_EDC9);
        add_vec("and",      enc_r(8, 9, 14, 0, 6'h24),      14, 32'hF0F0_1234);
        add_vec("or",       enc_r(8, 9, 15, 0, 6'h25),      15, 32'hFFFF_FFFD);
        add_vec("xor",      enc_r(8, 9, 16, 0, 6'h26),      16, 32'h0F0F_EDC9);
        add_vec("nor",      enc_r(8, 9, 17, 0, 6'h27),      17, 32'h0000_0002);
        add_vec("slt",      enc_r(8, 9, 18, 0, 6'h2A),      18, 32'd1);
        add_vec("sltu_t",   enc_r(8, 9, 19, 0, 6'h2B),      19, 32'd1);
        add_vec("sltu_f",   enc_r(9, 8, 20, 0, 6'h2B),      20, 32'd0);
        add_vec("sll",      enc_r(0, 8, 21, 4, 6'h00),      21, 32'h0F01_2340);
        add_vec("srl",      enc_r(0, 8, 22, 4, 6'h02),      22, 32'h0F0F_0123);
        add_vec("sra",      enc_r(0, 8, 23, 4, 6'h03),      23, 32'hFF0F_0123);
        add_vec("slti",     enc_i(6'h0A, 9, 24, -2),        24, 32'd1);
        add_vec("sltiu",    enc_i(6'h0B, 9, 25, -2),        25, 32'd1);
        add_vec("sltiu_f",  enc_i(6'h0B, 8, 6, 1),           6, 32'd0);
        add_vec("andi",     enc_i(6'h0C, 9, 26, 16'h8001),  26, 32'h0000_8001);
        add_vec("xori",     enc_i(6'h0E, 8, 27, 16'hFFFF),  27, 32'hF0F0_EDCB);
        add_vec("addiu",    enc_i(6'h09, 8, 2, -32'h1234),   2, 32'hF0F0_0000);
        add_vec("add_wrap", enc_r(9, 9, 7, 0, 6'h20),        7, 32'hFFFF_FFFA);
        add_vec("bad_op",   enc_i(6'h3F, 8, 3, 16'h0055),    3, 32'd0);
        add_vec("bad_fn",   enc_r(8, 9, 4, 0, 6'h3F),        4, 32'd0);
        add_vec("addi_r0",  enc_i(6'h08, 0, 0, 7),           0, 32'd0);
        prog.delete();
        foreach (vecs[i]) prog.push_back(vecs[i].instr);
        apply_stimulus();
        foreach (vecs[i]) begin
            expect_val(vecs[i].name, K_REG, vecs[i].dst, vecs[i].expected);
            expect_val({vecs[i].name, "_pc"}, K_PC, 0, RESET_PC + 32'(4 * (i + 1)));
            run_cycles(1);
            check_output();
        end

        // Store/load round trip, top-of-stack store, taken BEQ and untaken BNE.
        clock_run = 1'b0;
        prog = '{enc_i(6'h0F, 0, 8, 16'h1234), enc_i(6'h0D, 8, 8, 16'h5678),
                 enc_i(6'h2B, 0, 8, 16'h0010), enc_i(6'h23, 0, 9, 16'h0010),
                 enc_i(6'h2B, 29, 9, -4),      enc_i(6'h04, 8, 9, 1),
                 enc_i(6'h08, 0, 10, 1),       enc_i(6'h08, 0, 11, 2),
                 enc_i(6'h05, 8, 9, 5),        32'h0000_000C};
        apply_stimulus();
        run_cycles(9);
        expect_val("mem_dmem4", K_DMEM, 4, 32'h1234_5678);
        expect_val("mem_lw", K_REG, 9, 32'h1234_5678);
        expect_val("mem_sp", K_DMEM, 3070, 32'h1234_5678);
        expect_val("beq_skip", K_REG, 10, 32'd0);
        expect_val("beq_dest", K_REG, 11, 32'd2);
        expect_val("mem_pc", K_PC, 0, 32'h0000_3028);
        expect_val("mem_sys", K_SYS, 0, 32'd1);
        check_output();

        // Arithmetic program ending in SYSCALL, followed by a store and a register write.
        clock_run = 1'b0;
        prog = '{enc_i(6'h08, 0, 8, 5), enc_i(6'h08, 0, 9, -3),
                 enc_r(8, 9, 10, 0, 6'h20), enc_r(9, 8, 11, 0, 6'h2A),
                 32'h0000_000C, enc_i(6'h2B, 0, 10, 16'h0010), enc_i(6'h08, 0, 10, 9)};
        apply_stimulus();
        run_cycles(5);
        expect_val("ar_add", K_REG, 10, 32'h0000_0002);
        expect_val("ar_slt", K_REG, 11, 32'd1);
        expect_val("ar_sys", K_SYS, 0, 32'd1);
        expect_val("ar_pc", K_PC, 0, 32'h0000_3014);
        check_output();
        for (int k = 1; k <= 4; k++) begin
            run_cycles(1);
`ifdef SYSCALL_HALT_EN
            expect_val("halt_sys", K_SYS, 0, 32'd1);
            expect_val("halt_pc", K_PC, 0, 32'h0000_3014);
            expect_val("halt_reg", K_REG, 10, 32'h0000_0002);
            expect_val("halt_mem", K_DMEM, 4, 32'h1234_5678);
`else
            expect_val("pulse_sys", K_SYS, 0, 32'd0);
            expect_val("pulse_pc", K_PC, 0, 32'h0000_3014 + 32'(4 * k));
            expect_val("pulse_mem", K_DMEM, 4, 32'h0000_0002);
            expect_val("pulse_reg", K_REG, 10, (k >= 2) ? 32'd9 : 32'd2);
`endif
            check_output();
        end

        // Mid-program reset: state returns to reset values and no write commits while held.
        clock_run = 1'b0;
        apply_stimulus();
        run_cycles(2);
        expect_val("pre_rst_t0", K_REG, 8, 32'd5);
        expect_val("pre_rst_t1", K_REG, 9, 32'hFFFF_FFFD);
        check_output();
        reset = 1'b0;
        #1;
        expect_val("mid_rst_pc", K_PC, 0, RESET_PC);
        expect_val("mid_rst_t0", K_REG, 8, 32'd0);
        expect_val("mid_rst_gp", K_REG, 28, 32'h0000_1800);
        check_output();
        run_cycles(1);
        expect_val("held_rst_pc", K_PC, 0, RESET_PC);
        expect_val("held_rst_t0", K_REG, 8, 32'd0);
        check_output();
        reset = 1'b1;
        run_cycles(5);
        expect_val("rerun_add", K_REG, 10, 32'h0000_0002);
        expect_val("rerun_sys", K_SYS, 0, 32'd1);
        check_output();

        // Counting loop, JAL link, J, JR and a write to $0.
        clock_run = 1'b0;
        prog = '{enc_i(6'h08, 0, 9, 3),     enc_i(6'h08, 8, 8, 1),
                 enc_i(6'h05, 8, 9, -2),    enc_j(6'h03, 32'h3018),
                 enc_i(6'h08, 0, 12, 9),    enc_i(6'h08, 0, 12, 9),
                 enc_i(6'h08, 0, 0, 7),     enc_j(6'h02, 32'h3024),
                 enc_i(6'h08, 0, 13, 1),    enc_i(6'h08, 0, 14, 16'h3030),
                 enc_r(14, 0, 0, 0, 6'h08), enc_i(6'h08, 0, 13, 1),
                 32'h0000_000C};
        apply_stimulus();
        run_cycles(13);
        expect_val("loop_t0", K_REG, 8, 32'd3);
        expect_val("jal_ra", K_REG, 31, 32'h0000_3010);
        expect_val("zero_reg", K_REG, 0, 32'd0);
        expect_val("jal_skip", K_REG, 12, 32'd0);
        expect_val("j_skip", K_REG, 13, 32'd0);
        expect_val("jr_src", K_REG, 14, 32'h0000_3030);
        expect_val("loop_pc", K_PC, 0, 32'h0000_3034);
        expect_val("loop_sys", K_SYS, 0, 32'd1);
        check_output();

        clock_run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
